// File: rtl/iq_avg_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel IQ averager.
package iq_avg_pkg;

  localparam int unsigned NCH_DEF   = 2;
  localparam int unsigned NBITS_DEF = 16;
  localparam int unsigned ABITS_DEF = 8;
  localparam int unsigned CBITS_DEF = 13;
  localparam int unsigned SBITS_DEF = 16;
  localparam int unsigned SHW_DEF   = 5;

  function automatic int unsigned accw(input int unsigned nbits, input int unsigned abits);
    return nbits + abits;
  endfunction

  // Shifts beyond the accumulator width collapse to the widest meaningful shift.
  function automatic int unsigned eff_shift(input int unsigned shift, input int unsigned acc_w);
    return (shift >= acc_w) ? acc_w - 1 : shift;
  endfunction

  function automatic longint sat_to(input longint v, input int unsigned w);
    longint hi;
    longint lo;
    if (w >= 64) return v;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint round_bias(input int unsigned sh);
    return (sh == 0) ? longint'(0) : (longint'(1) <<< (sh - 1));
  endfunction

endpackage

// File: rtl/iq_avg_chan.sv
// One channel: saturating accumulator, sticky overflow, rounded/shifted/saturated result.
module iq_avg_chan
  import iq_avg_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned ABITS = ABITS_DEF,
  parameter int unsigned SHW   = SHW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_val,
  input  logic                    dump,
  input  logic signed [NBITS-1:0] sample,
  input  logic [SHW-1:0]          avg_shift,
  output logic signed [NBITS-1:0] average,
  output logic                    overflow
);

  localparam int unsigned ACCW = accw(NBITS, ABITS);

  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  seed;
  logic signed [NBITS-1:0] avg_next;
  logic                    ovf_live;
  logic                    sat;
  longint                  sum;
  longint                  sum_sat;
  longint                  rounded;
  longint                  scaled;
  int unsigned             sh;

  always_comb begin
    sum      = longint'(acc) + longint'(sample);
    sum_sat  = sat_to(sum, ACCW);
    sat      = (sum_sat != sum);
    seed     = {{ABITS{sample[NBITS-1]}}, sample};
    sh       = eff_shift(32'(avg_shift), ACCW);
    rounded  = longint'(acc) + round_bias(sh);
    scaled   = rounded >>> sh;
    avg_next = NBITS'(sat_to(scaled, NBITS));
  end

  // A sample arriving on the dump cycle seeds the next window instead of the closing one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      ovf_live <= 1'b0;
      average  <= '0;
      overflow <= 1'b0;
    end else if (!enable) begin
      acc      <= '0;
      ovf_live <= 1'b0;
      average  <= '0;
      overflow <= 1'b0;
    end else if (dump) begin
      average  <= avg_next;
      overflow <= ovf_live;
      acc      <= load_val ? seed : '0;
      ovf_live <= 1'b0;
    end else if (load_val) begin
      acc      <= ACCW'(sum_sat);
      ovf_live <= ovf_live | sat;
    end
  end

endmodule

// File: rtl/iq_multi_averager.sv
// N-channel windowed IQ averager: period/marker window control plus per-channel datapaths.
module iq_multi_averager
  import iq_avg_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned ABITS = ABITS_DEF,
  parameter int unsigned CBITS = CBITS_DEF,
  parameter int unsigned SBITS = SBITS_DEF,
  parameter int unsigned SHW   = SHW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 load_val,
  input  logic [NCH*NBITS-1:0] amplitude,
  input  logic                 msf_carrier_pulse,
  input  logic                 one_sec_marker,
  input  logic [CBITS-1:0]     number_msf_periods,
  input  logic [SHW-1:0]       avg_shift,
  output logic [NCH*NBITS-1:0] average,
  output logic                 valid,
  output logic [NCH-1:0]       overflow,
  output logic [SBITS-1:0]     sample_count,
  output logic                 marker_dump,
  output logic [CBITS-1:0]     counter
);

  logic             terminal;
  logic             dump;
  logic [SBITS-1:0] samp_cnt;

  always_comb begin
    terminal = msf_carrier_pulse && (number_msf_periods != '0) &&
               (counter == number_msf_periods - CBITS'(1));
    dump     = enable && (one_sec_marker || terminal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter      <= '0;
      samp_cnt     <= '0;
      sample_count <= '0;
      marker_dump  <= 1'b0;
      valid        <= 1'b0;
    end else if (!enable) begin
      counter      <= '0;
      samp_cnt     <= '0;
      sample_count <= '0;
      marker_dump  <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= dump;
      if (dump) begin
        counter      <= '0;
        sample_count <= samp_cnt;
        marker_dump  <= one_sec_marker;
        samp_cnt     <= load_val ? SBITS'(1) : '0;
      end else begin
        if (msf_carrier_pulse) counter <= counter + CBITS'(1);
        if (load_val && (samp_cnt != '1)) samp_cnt <= samp_cnt + SBITS'(1);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    iq_avg_chan #(
      .NBITS(NBITS),
      .ABITS(ABITS),
      .SHW  (SHW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .load_val (load_val),
      .dump     (dump),
      .sample   (amplitude[g*NBITS +: NBITS]),
      .avg_shift(avg_shift),
      .average  (average[g*NBITS +: NBITS]),
      .overflow (overflow[g])
    );
  end

endmodule

// File: tb/tb_iq_multi_averager.sv
// Directed-vector bench for iq_multi_averager (default and ABITS=2 instances).
module tb_iq_multi_averager;

  logic        clk = 1'b0;
  logic        rst_n, enable, load_val, pulse, marker;
  logic [31:0] amp;
  logic [12:0] nper;
  logic [4:0]  shift;

  logic [31:0] avg, avg2;
  logic        valid, valid2, mdump, mdump2;
  logic [1:0]  ovf, ovf2;
  logic [15:0] scnt, scnt2;
  logic [12:0] cnt, cnt2;

  int nvec = 0;
  int nerr = 0;
  int vcount = 0;
  int v0;

  always #5 clk = ~clk;

  // valid is sampled on the edge after it rises, so each pulse is counted once
  always @(posedge clk) if (valid) vcount++;

  iq_multi_averager dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load_val(load_val), .amplitude(amp),
    .msf_carrier_pulse(pulse), .one_sec_marker(marker), .number_msf_periods(nper),
    .avg_shift(shift), .average(avg), .valid(valid), .overflow(ovf),
    .sample_count(scnt), .marker_dump(mdump), .counter(cnt)
  );

  iq_multi_averager #(.ABITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load_val(load_val), .amplitude(amp),
    .msf_carrier_pulse(pulse), .one_sec_marker(marker), .number_msf_periods(nper),
    .avg_shift(shift), .average(avg2), .valid(valid2), .overflow(ovf2),
    .sample_count(scnt2), .marker_dump(mdump2), .counter(cnt2)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic lv, input logic p, input logic m, input int i, input int q);
    load_val = lv; pulse = p; marker = m;
    amp = {16'(q), 16'(i)};
    tick();
    load_val = 1'b0; pulse = 1'b0; marker = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    nvec++; if (avg !== 32'd0) begin nerr++; $display("FAIL reset_avg got %h want 0", avg); end
    nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", valid); end
    nvec++; if (ovf !== 2'b00) begin nerr++; $display("FAIL reset_ovf got %b want 00", ovf); end
    nvec++; if (scnt !== 16'd0) begin nerr++; $display("FAIL reset_scnt got %0d want 0", scnt); end
    nvec++; if (mdump !== 1'b0) begin nerr++; $display("FAIL reset_mdump got %b want 0", mdump); end
    nvec++; if (cnt !== 13'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    rst_n = 1'b1; enable = 1'b1;
    tick();
  endtask

  task automatic test_period_window();
    nper = 13'd4; shift = 5'd2; v0 = vcount;
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 4; s++) drive(1'b1, 1'b0, 1'b0, 100, -100);
      if (p < 3) drive(1'b0, 1'b1, 1'b0, 0, 0);
    end
    nvec++; if (cnt !== 13'd3) begin nerr++; $display("FAIL per_cnt3 got %0d want 3", cnt); end
    nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL per_early_valid got %b want 0", valid); end
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    nvec++; if (valid !== 1'b1) begin nerr++; $display("FAIL per_valid got %b want 1", valid); end
    nvec++; if ($signed(avg[15:0]) !== 16'sd400) begin nerr++; $display("FAIL per_avg_i got %0d want 400", $signed(avg[15:0])); end
    nvec++; if ($signed(avg[31:16]) !== -16'sd400) begin nerr++; $display("FAIL per_avg_q got %0d want -400", $signed(avg[31:16])); end
    nvec++; if (scnt !== 16'd16) begin nerr++; $display("FAIL per_scnt got %0d want 16", scnt); end
    nvec++; if (mdump !== 1'b0) begin nerr++; $display("FAIL per_mdump got %b want 0", mdump); end
    nvec++; if (cnt !== 13'd0) begin nerr++; $display("FAIL per_cnt0 got %0d want 0", cnt); end
    tick();
    nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL per_valid_width got %b want 0", valid); end
    nvec++; if ($signed(avg[15:0]) !== 16'sd400) begin nerr++; $display("FAIL per_hold got %0d want 400", $signed(avg[15:0])); end
    tick();
    nvec++; if (vcount - v0 !== 1) begin nerr++; $display("FAIL per_vcount got %0d want 1", vcount - v0); end
  endtask

  task automatic test_marker();
    nper = 13'd4; shift = 5'd0;
    drive(1'b1, 1'b0, 1'b0, 7, -7);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 7, -7);
    drive(1'b1, 1'b0, 1'b0, 7, -7);
    nvec++; if (cnt !== 13'd1) begin nerr++; $display("FAIL mk_cnt1 got %0d want 1", cnt); end
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    nvec++; if (valid !== 1'b1) begin nerr++; $display("FAIL mk_valid got %b want 1", valid); end
    nvec++; if ($signed(avg[15:0]) !== 16'sd21) begin nerr++; $display("FAIL mk_avg_i got %0d want 21", $signed(avg[15:0])); end
    nvec++; if ($signed(avg[31:16]) !== -16'sd21) begin nerr++; $display("FAIL mk_avg_q got %0d want -21", $signed(avg[31:16])); end
    nvec++; if (mdump !== 1'b1) begin nerr++; $display("FAIL mk_mdump got %b want 1", mdump); end
    nvec++; if (cnt !== 13'd0) begin nerr++; $display("FAIL mk_cnt0 got %0d want 0", cnt); end
    nvec++; if (scnt !== 16'd3) begin nerr++; $display("FAIL mk_scnt got %0d want 3", scnt); end
  endtask

  task automatic test_back_to_back();
    nper = 13'd0; shift = 5'd0;
    drive(1'b1, 1'b0, 1'b0, 5, 1);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 5, 1);
    nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL b2b_zero_per_valid got %b want 0", valid); end
    drive(1'b1, 1'b0, 1'b1, 5, 1);
    nvec++; if ($signed(avg[15:0]) !== 16'sd10) begin nerr++; $display("FAIL b2b_w1_i got %0d want 10", $signed(avg[15:0])); end
    nvec++; if ($signed(avg[31:16]) !== 16'sd2) begin nerr++; $display("FAIL b2b_w1_q got %0d want 2", $signed(avg[31:16])); end
    nvec++; if (scnt !== 16'd2) begin nerr++; $display("FAIL b2b_w1_scnt got %0d want 2", scnt); end
    drive(1'b1, 1'b0, 1'b0, 5, 1);
    nper = 13'd1; v0 = vcount;
    drive(1'b0, 1'b1, 1'b1, 0, 0);
    nvec++; if ($signed(avg[15:0]) !== 16'sd10) begin nerr++; $display("FAIL b2b_w2_i got %0d want 10", $signed(avg[15:0])); end
    nvec++; if (scnt !== 16'd2) begin nerr++; $display("FAIL b2b_w2_scnt got %0d want 2", scnt); end
    nvec++; if (mdump !== 1'b1) begin nerr++; $display("FAIL b2b_both_mdump got %b want 1", mdump); end
    tick(); tick();
    nvec++; if (vcount - v0 !== 1) begin nerr++; $display("FAIL b2b_single_dump got %0d want 1", vcount - v0); end
  endtask

  task automatic test_saturation();
    nper = 13'd0; shift = 5'd0;
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b0, 32767, -32768);
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    nvec++; if (ovf2 !== 2'b11) begin nerr++; $display("FAIL sat_ovf2 got %b want 11", ovf2); end
    nvec++; if (avg2[15:0] !== 16'h7FFF) begin nerr++; $display("FAIL sat_avg2_i got %h want 7fff", avg2[15:0]); end
    nvec++; if (avg2[31:16] !== 16'h8000) begin nerr++; $display("FAIL sat_avg2_q got %h want 8000", avg2[31:16]); end
    nvec++; if (scnt2 !== 16'd8) begin nerr++; $display("FAIL sat_scnt2 got %0d want 8", scnt2); end
    nvec++; if (ovf !== 2'b00) begin nerr++; $display("FAIL sat_wide_ovf got %b want 00", ovf); end
    nvec++; if (avg[15:0] !== 16'h7FFF) begin nerr++; $display("FAIL sat_wide_avg got %h want 7fff", avg[15:0]); end
    drive(1'b1, 1'b0, 1'b0, 1, 0);
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    nvec++; if (ovf2 !== 2'b00) begin nerr++; $display("FAIL sat_clear_ovf2 got %b want 00", ovf2); end
    nvec++; if (avg2[15:0] !== 16'd1) begin nerr++; $display("FAIL sat_next_avg2 got %h want 0001", avg2[15:0]); end
  endtask

  task automatic test_rounding();
    nper = 13'd0; shift = 5'd1;
    drive(1'b1, 1'b0, 1'b0, -3, 3);
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    nvec++; if ($signed(avg[15:0]) !== -16'sd1) begin nerr++; $display("FAIL rnd_neg got %0d want -1", $signed(avg[15:0])); end
    nvec++; if ($signed(avg[31:16]) !== 16'sd2) begin nerr++; $display("FAIL rnd_pos got %0d want 2", $signed(avg[31:16])); end
  endtask

  task automatic test_enable();
    nper = 13'd0; shift = 5'd0;
    drive(1'b1, 1'b0, 1'b0, 9, 9);
    enable = 1'b0;
    tick();
    nvec++; if (avg !== 32'd0) begin nerr++; $display("FAIL en_avg got %h want 0", avg); end
    nvec++; if (scnt !== 16'd0 || mdump !== 1'b0 || valid !== 1'b0) begin nerr++; $display("FAIL en_status got scnt=%0d mdump=%b valid=%b want 0", scnt, mdump, valid); end
    enable = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4, 4);
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    nvec++; if ($signed(avg[15:0]) !== 16'sd4) begin nerr++; $display("FAIL en_fresh_avg got %0d want 4", $signed(avg[15:0])); end
    nvec++; if (scnt !== 16'd1) begin nerr++; $display("FAIL en_fresh_scnt got %0d want 1", scnt); end
  endtask

  task automatic test_async_reset();
    nper = 13'd2; shift = 5'd0;
    drive(1'b1, 1'b0, 1'b0, 6, 6);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (avg !== 32'd0) begin nerr++; $display("FAIL ar_avg got %h want 0", avg); end
    nvec++; if (cnt !== 13'd0) begin nerr++; $display("FAIL ar_cnt got %0d want 0", cnt); end
    nvec++; if (scnt !== 16'd0 || mdump !== 1'b0) begin nerr++; $display("FAIL ar_status got scnt=%0d mdump=%b want 0", scnt, mdump); end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4, -4);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    nvec++; if (cnt !== 13'd1 || valid !== 1'b0) begin nerr++; $display("FAIL ar_restart got cnt=%0d valid=%b want 1/0", cnt, valid); end
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    nvec++; if (valid !== 1'b1) begin nerr++; $display("FAIL ar_valid got %b want 1", valid); end
    nvec++; if ($signed(avg[15:0]) !== 16'sd4 || $signed(avg[31:16]) !== -16'sd4) begin nerr++; $display("FAIL ar_avg_post got %0d/%0d want 4/-4", $signed(avg[15:0]), $signed(avg[31:16])); end
    nvec++; if (scnt !== 16'd1) begin nerr++; $display("FAIL ar_scnt got %0d want 1", scnt); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load_val = 1'b0; pulse = 1'b0; marker = 1'b0;
    amp = '0; nper = '0; shift = '0;
    test_reset();
    test_period_window();
    test_marker();
    test_back_to_back();
    test_saturation();
    test_rounding();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/iq_multi_averager.md
Name: iq_multi_averager

Overview:
Parametrised N-channel successor to the single-channel IQ averager. Accumulates signed samples per channel (I, Q, optionally more) over a window closed either by a count of MSF carrier periods or by the one-second marker. Emits a rounded, saturated, shift-scaled average per channel with a one-cycle valid pulse, plus overflow and sample-count status. Sits between the IQ demodulator and the AXI status/readback logic.

Parameters:
NCH, 2, number of channels (ch0 = I, ch1 = Q)
NBITS, 16, signed sample and average width
ABITS, 8, accumulator headroom bits; ACCW = NBITS+ABITS
CBITS, 13, carrier-period counter width
SBITS, 16, sample counter width
SHW, 5, width of avg_shift (0..ACCW-1 used)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  high = run; low = hold everything cleared
load_val  in  1  sample strobe
amplitude  in  NCH*NBITS  packed signed samples, ch0 in LSBs
msf_carrier_pulse  in  1  one-cycle carrier-period tick
one_sec_marker  in  1  one-cycle frame marker, forces dump
number_msf_periods  in  CBITS  periods per window; 0 = marker-only
avg_shift  in  SHW  right-shift applied to accumulator
average  out  NCH*NBITS  packed signed averages
valid  out  1  one-cycle pulse, average/status updated
overflow  out  NCH  per-channel: accumulator saturated during window
sample_count  out  SBITS  samples in completed window (saturating)
marker_dump  out  1  window closed by one_sec_marker
counter  out  CBITS  live carrier-period count

Behaviour:
- Reset (rst_n low, async): accumulators, counter, sample counter, average, overflow, sample_count, marker_dump, valid all 0.
- enable low: same clear as reset, synchronous; valid held 0.
- Period counter: +1 on msf_carrier_pulse. Terminal event = msf_carrier_pulse && counter == number_msf_periods-1 (number_msf_periods != 0).
- Dump event = one_sec_marker OR terminal event. Marker has priority; marker_dump = one_sec_marker at dump.
- On dump cycle: counter <= 0; result registers latch from pre-dump accumulator; valid high the following cycle (latency 1 from dump event), exactly one cycle.
- load_val on dump cycle: sample seeds new window (acc <= sample, sample counter <= 1), never lost or double-counted.
- Accumulate: acc <= sat_ACCW(acc + sign-extended sample); on saturation set channel's sticky overflow bit for current window; cleared at window start.
- Output: r = acc + (shift>0 ? 1<<(shift-1) : 0) (round half up, computed ACCW+1 wide), then arithmetic >> avg_shift, then saturate to NBITS signed. avg_shift >= ACCW treated as ACCW-1.
- sample_count saturates at 2^SBITS-1.
- number_msf_periods change mid-window takes effect on next comparison; if counter already >= new value, no terminal event until marker (counter wraps naturally at 2^CBITS).
- Marker and terminal same cycle: single dump, marker_dump=1.
- Outputs average/overflow/sample_count/marker_dump hold between valid pulses.

Decomposition:
- Package iq_avg_pkg: ACCW function, saturation/round helper functions, default parameter constants.
- Sub-module iq_avg_chan: one channel's accumulator, overflow flag, round/shift/saturate; instantiated NCH times by generate. Top holds counters, dump logic, valid.

Test Plan:
- NCH=2, number_msf_periods=4, avg_shift=2, I=+100, Q=-100 on every one of 4 load_val per period, 4 periods -> valid once after 4th carrier pulse, I avg=(1600+2)>>2=400, Q=-400, sample_count=16, marker_dump=0.
- one_sec_marker after 3 samples of 7, shift=0 -> valid next cycle, I avg=21, marker_dump=1, counter=0.
- load_val coincident with dump, sample 5 -> next window ends with sample_count including it; previous window excludes it.
- ABITS=2, samples 0x7FFF x8 -> acc saturates at 2^17-1, overflow[0]=1, average=0x7FFF (shift 0 saturated); overflow clears next window.
- Rounding: acc=-3, shift=1 -> (-3+1)>>1=-1; acc=3 -> 2.
- rst_n low mid-window -> all outputs 0 immediately (async); first window after release starts counting from 0.
